// File: rtl/kernel_mem_pkg.sv
// Shared types and default sizing for the kernel weight memory write path.
package kernel_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int DEF_KERNEL_BRAM_NUM           = 4;
    localparam int DEF_KERNEL_BRAM_ADDRESS_WIDTH = 16;
    localparam int DEF_DATA_WIDTH                = 32;
    localparam int DEF_KERNEL_SIZE               = 9;

endpackage

// File: rtl/kernel_mem_loader.sv
// Write-side sequencer for the kernel weight BRAM bank: takes a valid/ready
// stream of weight words and deals whole kernels round-robin across banks.
module kernel_mem_loader
    import kernel_mem_pkg::*;
#(
    parameter int KERNEL_BRAM_NUM           = DEF_KERNEL_BRAM_NUM,
    parameter int KERNEL_BRAM_ADDRESS_WIDTH = DEF_KERNEL_BRAM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH                = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE               = DEF_KERNEL_SIZE
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [15:0]                          i_num_kernels,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [DATA_WIDTH-1:0]                i_data,
    output logic [0:0]                           o_enable  [0:KERNEL_BRAM_NUM-1],
    output logic [0:0]                           o_wenable [0:KERNEL_BRAM_NUM-1],
    output logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0] o_address [0:KERNEL_BRAM_NUM-1],
    output logic [DATA_WIDTH-1:0]                o_bram_data,
    output logic                                 o_busy,
    output logic                                 o_done
);

    localparam int AW     = KERNEL_BRAM_ADDRESS_WIDTH;
    localparam int BANK_W = (KERNEL_BRAM_NUM > 1) ? $clog2(KERNEL_BRAM_NUM) : 1;
    localparam int WORD_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(KERNEL_SIZE - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(KERNEL_BRAM_NUM - 1);
    localparam logic [AW-1:0]     KS_ADDR   = AW'(KERNEL_SIZE);

    loader_state_t     state, state_next;

    logic [WORD_W-1:0] word_cnt;
    logic [BANK_W-1:0] bank_cnt;
    logic [AW-1:0]     base_addr;
    logic [15:0]       kern_cnt;
    logic [15:0]       num_kernels;

    logic              handshake;
    logic              last_word;
    logic [AW-1:0]     wr_addr;

    // Only LOAD accepts words; ready is a pure decode of the state register.
    assign o_ready   = (state == LOAD);
    assign handshake = o_ready && i_valid;
    assign last_word = handshake && (word_cnt == WORD_LAST)
                       && (kern_cnt == (num_kernels - 16'd1));
    // Address arithmetic wraps silently at the port width.
    assign wr_addr   = base_addr + AW'(word_cnt);

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode; a zero-kernel request goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = (i_num_kernels == 16'd0) ? DONE : LOAD;
            end
            LOAD: begin
                if (last_word) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Placement counters: word within kernel, bank, per-bank base, kernel count.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            word_cnt    <= '0;
            bank_cnt    <= '0;
            base_addr   <= '0;
            kern_cnt    <= '0;
            num_kernels <= '0;
        end else if (state == IDLE && i_start) begin
            word_cnt    <= '0;
            bank_cnt    <= '0;
            base_addr   <= '0;
            kern_cnt    <= '0;
            num_kernels <= i_num_kernels;
        end else if (handshake) begin
            if (word_cnt == WORD_LAST) begin
                word_cnt <= '0;
                kern_cnt <= kern_cnt + 16'd1;
                if (bank_cnt == BANK_LAST) begin
                    bank_cnt  <= '0;
                    base_addr <= base_addr + KS_ADDR;
                end else begin
                    bank_cnt <= bank_cnt + BANK_W'(1);
                end
            end else begin
                word_cnt <= word_cnt + WORD_W'(1);
            end
        end
    end

    // Registered write port and status; one bank at most, idle banks park at 0.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
                o_enable[b]  <= 1'b0;
                o_wenable[b] <= 1'b0;
                o_address[b] <= '0;
            end
            o_bram_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            for (int b = 0; b < KERNEL_BRAM_NUM; b++) begin
                if (handshake && bank_cnt == BANK_W'(b)) begin
                    o_enable[b]  <= 1'b1;
                    o_wenable[b] <= 1'b1;
                    o_address[b] <= wr_addr;
                end else begin
                    o_enable[b]  <= 1'b0;
                    o_wenable[b] <= 1'b0;
                    o_address[b] <= '0;
                end
            end
            if (handshake) o_bram_data <= i_data;
            o_busy <= (state_next != IDLE);
            o_done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_kernel_mem_loader.sv
// Directed bench for kernel_mem_loader with default sizing (4 banks, 3x3).
module tb_kernel_mem_loader;

    localparam int NB = 4;
    localparam int KS = 9;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_num_kernels = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [0:0]  o_enable  [0:NB-1];
    logic [0:0]  o_wenable [0:NB-1];
    logic [15:0] o_address [0:NB-1];
    logic [31:0] o_bram_data;
    logic        o_busy;
    logic        o_done;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_data = '0;
    logic [31:0] mem [NB][32];
    logic [NB-1:0] en_mask, wen_mask;

    kernel_mem_loader dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_num_kernels(i_num_kernels), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_enable(o_enable), .o_wenable(o_wenable),
        .o_address(o_address), .o_bram_data(o_bram_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    always_comb begin
        en_mask  = '0;
        wen_mask = '0;
        for (int b = 0; b < NB; b++) begin
            en_mask[b]  = o_enable[b][0];
            wen_mask[b] = o_wenable[b][0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_bank(input int i);
        return (i / KS) % NB;
    endfunction

    function automatic int exp_addr(input int i);
        return ((i / KS) / NB) * KS + (i % KS);
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_write(input int idx);
        int b, a;
        logic [15:0] others;
        b = exp_bank(idx);
        a = exp_addr(idx);
        others = '0;
        for (int k = 0; k < NB; k++) if (k != b) others |= o_address[k];
        chk($sformatf("en_w%0d", idx), 32'(en_mask), 32'(1 << b));
        chk($sformatf("wen_w%0d", idx), 32'(wen_mask), 32'(1 << b));
        chk($sformatf("addr_w%0d", idx), 32'(o_address[b]), 32'(a));
        chk($sformatf("idle_addr_w%0d", idx), 32'(others), 32'd0);
        chk($sformatf("data_w%0d", idx), o_bram_data, 32'(idx));
        exp_data = 32'(idx);
        for (int k = 0; k < NB; k++)
            if (en_mask[k] && o_address[k] < 16'd32) mem[k][o_address[k][4:0]] = o_bram_data;
    endtask

    task automatic check_nowrite(input string tag);
        logic [15:0] addr_or;
        addr_or = '0;
        for (int k = 0; k < NB; k++) addr_or |= o_address[k];
        chk({tag, "_en"}, 32'(en_mask), 32'd0);
        chk({tag, "_wen"}, 32'(wen_mask), 32'd0);
        chk({tag, "_addr"}, 32'(addr_or), 32'd0);
        chk({tag, "_hold"}, o_bram_data, exp_data);
    endtask

    task automatic check_idle(input string tag);
        check_nowrite(tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    // Start a load of nk kernels and push nwords words; optionally inject a
    // stray start pulse while word inj_at is being transferred.
    task automatic run_load(input int nk, input bit gaps, input int inj_at, input int nwords);
        int idx, cyc;
        bit v;
        idx = 0;
        cyc = 0;
        i_num_kernels = 16'(nk);
        i_start = 1'b1;
        i_valid = 1'b0;
        tick();
        i_start = 1'b0;
        chk("start_ready", 32'(o_ready), 32'd1);
        chk("start_busy", 32'(o_busy), 32'd1);
        while (idx < nwords && cyc < 1000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_valid = v;
            i_data  = 32'(idx);
            if (v && idx == inj_at) begin
                i_start = 1'b1;
                i_num_kernels = 16'd2;
            end
            tick();
            cyc++;
            i_start = 1'b0;
            i_num_kernels = 16'(nk);
            if (v) begin
                check_write(idx);
                chk($sformatf("done_w%0d", idx), 32'(o_done), 32'(idx == nk*KS - 1));
                chk($sformatf("ready_w%0d", idx), 32'(o_ready), 32'(idx != nk*KS - 1));
                chk($sformatf("busy_w%0d", idx), 32'(o_busy), 32'd1);
                idx++;
            end else begin
                check_nowrite("gap");
                chk("gap_done", 32'(o_done), 32'd0);
            end
        end
        chk("load_word_budget", 32'(idx), 32'(nwords));
        i_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 5 * KS; i++)
            chk($sformatf("%s_b%0d_a%0d", tag, exp_bank(i), exp_addr(i)),
                mem[exp_bank(i)][exp_addr(i)], 32'(i));
    endtask

    task automatic clear_mem();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 32; a++) mem[b][a] = 32'hdead_beef;
    endtask

    initial begin
        // Reset held with start/valid asserted.
        i_reset = 1'b0;
        i_start = 1'b1;
        i_valid = 1'b1;
        i_num_kernels = 16'd5;
        i_data = 32'h55;
        repeat (3) tick();
        exp_data = '0;
        check_idle("rst");
        i_reset = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        tick();
        check_idle("post_rst");

        // Full continuous load of 5 kernels.
        clear_mem();
        run_load(5, 1'b0, -1, 45);
        tick();
        check_idle("full_after");
        check_mem("full");

        // Same load with random valid gaps.
        clear_mem();
        run_load(5, 1'b1, -1, 45);
        tick();
        check_idle("gap_after");
        check_mem("gaps");

        // Zero kernels.
        i_num_kernels = 16'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_nowrite("zero_t1");
        chk("zero_t1_done", 32'(o_done), 32'd1);
        chk("zero_t1_busy", 32'(o_busy), 32'd1);
        chk("zero_t1_ready", 32'(o_ready), 32'd0);
        tick();
        check_idle("zero_t2");

        // Reset after word 20, then reload one kernel.
        run_load(5, 1'b0, -1, 21);
        i_reset = 1'b0;
        i_valid = 1'b1;
        i_data = 32'd99;
        tick();
        exp_data = '0;
        check_idle("midrst");
        i_reset = 1'b1;
        tick();
        check_idle("midrst_idle");
        i_valid = 1'b0;
        run_load(1, 1'b0, -1, 9);
        tick();
        check_idle("reload_after");

        // Stray start during word 10 of a 5-kernel load.
        run_load(5, 1'b0, 10, 45);
        tick();
        check_idle("busy_start_after");
        tick();
        check_idle("busy_start_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kernel_mem_loader.md
# kernel_mem_loader

Write-side sequencer for the kernel weight memory bank. Accepts a valid/ready stream of kernel weight words and distributes whole kernels round-robin across `KERNEL_BRAM_NUM` kernel BRAMs. It drives each bank's write-port enable, write-enable and address, plus the shared write-data bus. It sits between the DMA/weight-fetch stream and the kernel memory, and signals completion to the layer controller so convolution reads can begin.

## Interface

**Parameters**
- `KERNEL_BRAM_NUM`, 4: number of kernel BRAM banks.
- `KERNEL_BRAM_ADDRESS_WIDTH`, 16: per-bank address width.
- `DATA_WIDTH`, 32: weight word width.
- `KERNEL_SIZE`, 9: words per kernel (3x3). Must be ≥ 1.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `i_clock`, in, 1: clock.
  - `i_reset`, in, 1: synchronous, active-low reset (0 = reset).
- Control:
  - `i_start`, in, 1: single-cycle load request; sampled only in IDLE.
  - `i_num_kernels`, in, 16: total kernels to load; latched on accepted `i_start`.
- Input stream:
  - `i_valid`, in, 1: input word valid.
  - `o_ready`, out, 1: loader accepts a word.
  - `i_data`, in, `DATA_WIDTH`: weight word.
- BRAM write side:
  - `o_enable`, out, `[0:0]` x `[0:KERNEL_BRAM_NUM-1]`: per-bank port enable.
  - `o_wenable`, out, `[0:0]` x `[0:KERNEL_BRAM_NUM-1]`: per-bank write enable.
  - `o_address`, out, `KERNEL_BRAM_ADDRESS_WIDTH` x `[0:KERNEL_BRAM_NUM-1]`: per-bank write address.
  - `o_bram_data`, out, `DATA_WIDTH`: shared write data.
- Status:
  - `o_busy`, out, 1: high outside IDLE.
  - `o_done`, out, 1: one-cycle completion pulse.

## Operation

- **FSM states: IDLE, LOAD, DONE.**
  - IDLE → LOAD on `i_start` with `i_num_kernels` ≠ 0.
  - IDLE → DONE on `i_start` with `i_num_kernels` = 0.
  - LOAD → DONE on the handshake of the final word (kernel `N-1`, word `KERNEL_SIZE-1`).
  - DONE → IDLE unconditionally after one cycle.
- **Handshake:** `o_ready` = (state == LOAD). A word transfers when `i_valid && o_ready`. No skid buffer.
- **Counters:**
  - `word_cnt` counts 0..`KERNEL_SIZE-1`.
  - `bank_cnt` counts 0..`KERNEL_BRAM_NUM-1`, advancing when `word_cnt` wraps.
  - `base_addr` advances by `KERNEL_SIZE` when `bank_cnt` wraps.
  - `kern_cnt` counts accepted kernels.
- **Placement:** kernel k goes to bank `k % KERNEL_BRAM_NUM`, address `(k / KERNEL_BRAM_NUM)*KERNEL_SIZE + word`.
- **Address arithmetic:** modulo 2^`KERNEL_BRAM_ADDRESS_WIDTH`; silent wrap on overflow. Sizing is the controller's responsibility.
- **Write outputs:**
  - At most one bank has `o_enable`/`o_wenable` high per cycle; both are high together.
  - Non-selected banks hold enable 0 and address 0.
  - `o_bram_data` holds its last value when no write is issued.
- **Ignored inputs:** `i_start` is ignored in LOAD and DONE. `i_valid` outside LOAD is ignored.
- **Reset** (`i_reset` = 0 on a rising edge, at any time including mid-load):
  - State returns to IDLE and all counters clear.
  - All outputs read 0 from the next cycle.
  - Any pending registered write is dropped.
  - Partial bank contents are not cleared.

## Timing

- All outputs are registered, except `o_ready`, which is decoded from the state register.
- **Write latency:** handshake in cycle t → `o_enable[b]` = `o_wenable[b]` = 1, `o_address[b]`, and `o_bram_data` valid in cycle t+1 only.
- **Start:** `i_start` accepted in cycle t → `o_ready` = 1 and `o_busy` = 1 from cycle t+1.
- **Completion:** last handshake in cycle t → state DONE in t+1. `o_done` = 1 and the final write are presented in t+1. `o_ready` = 0 from t+1. `o_busy` = 0 from t+2.
- **Throughput:** one word per cycle with continuous `i_valid`. N kernels take `N*KERNEL_SIZE` cycles plus 2.
- **Zero kernels:** `o_done` one cycle after `i_start`, with no writes.

## Structure

- **Package `kernel_mem_pkg`:**
  - `loader_state_t` enum (IDLE, LOAD, DONE).
  - Shared default constants for `KERNEL_BRAM_NUM`, `KERNEL_BRAM_ADDRESS_WIDTH`, `DATA_WIDTH` and `KERNEL_SIZE`.
- **Sub-modules:** none is natural. The FSM and four counters stay in one module, instantiated beside the kernel memory in the layer top.

## Test plan

Defaults: 4 banks, `KERNEL_SIZE` = 9.

1. **Reset:** hold `i_reset` = 0 for 3 cycles with `i_valid` = 1 and `i_start` = 1 → every output 0, no writes.
2. **Full load:** `i_num_kernels` = 5, 45 continuous words with data = index →
   - word 0 → bank0 addr0; word 9 → bank1 addr0; word 27 → bank3 addr0; word 36 → bank0 addr9; word 44 → bank0 addr17.
   - `o_done` in the same cycle as the word-44 write; exactly 45 write cycles.
3. **Backpressure gaps:** same load with `i_valid` randomly low 50% of cycles → no write in cycles following gaps; final bank contents identical to scenario 2.
4. **Zero kernels:** `i_start` with `i_num_kernels` = 0 → `o_done` pulse at t+1, `o_busy` high only at t+1, `o_ready` never high.
5. **Reset mid-load:** reset after word 20 of scenario 2, then reload 1 kernel → no write after reset; new word 0 goes to bank0 addr0.
6. **Start while busy:** pulse `i_start` with `i_num_kernels` = 2 during word 10 of a 5-kernel load → ignored; load finishes after 45 words.
